// File: rtl/psum_accumulator.sv
// Sums NUM_TERMS adder-tree partial sums into a saturating ACC_W result; result registered one edge after the final beat.
// in_ready drops combinationally while a result is held (out_valid && !out_ready) or clear is asserted.
module psum_accumulator #(
  parameter int IN_W      = 16,
  parameter int ACC_W     = 24,
  parameter int NUM_TERMS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat
);

  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat_pend;

  logic [ACC_W:0]   sum;
  logic             ovf;
  logic [ACC_W-1:0] sum_clamp;
  logic             accept;
  logic             last_beat;

  // One extra bit catches the carry out; any carry means the result is pinned at all-ones.
  always_comb begin
    sum       = {1'b0, acc} + (ACC_W + 1)'(in_data);
    ovf       = sum[ACC_W];
    sum_clamp = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  end

  // Holding a result, clearing or in reset all block the tree; in_valid never feeds back here.
  assign in_ready  = reset && !clear && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      cnt       <= '0;
      sat_pend  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (clear) begin
        acc      <= '0;
        cnt      <= '0;
        sat_pend <= 1'b0;
      end else if (accept) begin
        if (last_beat) begin
          acc      <= '0;
          cnt      <= '0;
          sat_pend <= 1'b0;
          out_data <= sum_clamp;
          out_sat  <= sat_pend | ovf;
        end else begin
          acc      <= sum_clamp;
          cnt      <= cnt + 1'b1;
          sat_pend <= sat_pend | ovf;
        end
      end

      // A completing beat wins over a drain, so back-to-back results leave no bubble.
      if (accept && last_beat)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench: default, 16-bit-accumulator and single-term instances share clock, reset and inputs.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        rdy_d, ov_d, sat_d;
  logic [23:0] od_d;
  logic        rdy_s, ov_s, sat_s;
  logic [15:0] od_s;
  logic        rdy_o, ov_o, sat_o;
  logic [23:0] od_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  psum_accumulator #(.IN_W(16), .ACC_W(24), .NUM_TERMS(4)) u_def (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy_d),
    .in_data(in_data), .out_valid(ov_d), .out_ready(out_ready), .out_data(od_d), .out_sat(sat_d)
  );

  psum_accumulator #(.IN_W(16), .ACC_W(16), .NUM_TERMS(4)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy_s),
    .in_data(in_data), .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s), .out_sat(sat_s)
  );

  psum_accumulator #(.IN_W(16), .ACC_W(24), .NUM_TERMS(1)) u_one (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy_o),
    .in_data(in_data), .out_valid(ov_o), .out_ready(out_ready), .out_data(od_o), .out_sat(sat_o)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        clr;
    logic        ordy;
    logic        rdy;
    logic        ov;
    logic [23:0] od;
    logic        sat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int v, input int d, input int clr, input int ordy,
                              input int rdy, input int ov, input int od, input int sat);
    vec_t m;
    m.v    = v[0];
    m.d    = d[15:0];
    m.clr  = clr[0];
    m.ordy = ordy[0];
    m.rdy  = rdy[0];
    m.ov   = ov[0];
    m.od   = od[23:0];
    m.sat  = sat[0];
    return m;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, want %0h", nm, idx, act, exp);
    end
  endtask

  // Inputs change on the falling edge; registered outputs are sampled 1ns after the rising edge.
  task automatic drive(input logic v, input logic [15:0] d, input logic clr, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    clear     = clr;
    out_ready = ordy;
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic clr, input logic ordy);
    drive(v, d, clr, ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state, then in_ready comes up once reset is released.
    repeat (2) @(negedge clk);
    chk("rst_ov",  0, 32'(ov_d),  32'h0);
    chk("rst_od",  0, 32'(od_d),  32'h0);
    chk("rst_sat", 0, 32'(sat_d), 32'h0);
    chk("rst_rdy", 0, 32'(rdy_d), 32'h0);
    chk("rst_rdy_one", 0, 32'(rdy_o), 32'h0);
    reset = 1'b1;
    #1;
    chk("rel_rdy", 0, 32'(rdy_d), 32'h1);

    // Table for the default instance: {v, d, clr, ordy} -> {in_ready before edge, ov, od, sat after edge}.
    tbl.push_back(mk(1, 100, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 200, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 300, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 400, 0, 1, 1, 1, 1000, 0));
    tbl.push_back(mk(0, 0,   0, 1, 1, 0, 1000, 0));
    tbl.push_back(mk(1, 100, 0, 0, 1, 0, 1000, 0));
    tbl.push_back(mk(1, 200, 0, 0, 1, 0, 1000, 0));
    tbl.push_back(mk(1, 300, 0, 0, 1, 0, 1000, 0));
    tbl.push_back(mk(1, 400, 0, 0, 1, 1, 1000, 0));
    tbl.push_back(mk(1, 1,   0, 0, 0, 1, 1000, 0));
    tbl.push_back(mk(1, 1,   0, 0, 0, 1, 1000, 0));
    tbl.push_back(mk(1, 1,   0, 1, 1, 0, 1000, 0));
    tbl.push_back(mk(1, 1,   0, 1, 1, 0, 1000, 0));
    tbl.push_back(mk(1, 1,   0, 1, 1, 0, 1000, 0));
    tbl.push_back(mk(1, 1,   0, 1, 1, 1, 4, 0));
    tbl.push_back(mk(0, 0,   0, 1, 1, 0, 4, 0));
    tbl.push_back(mk(1, 10,  0, 1, 1, 0, 4, 0));
    tbl.push_back(mk(1, 20,  0, 1, 1, 0, 4, 0));
    tbl.push_back(mk(1, 999, 1, 1, 0, 0, 4, 0));
    tbl.push_back(mk(1, 1,   0, 1, 1, 0, 4, 0));
    tbl.push_back(mk(1, 2,   0, 1, 1, 0, 4, 0));
    tbl.push_back(mk(1, 3,   0, 1, 1, 0, 4, 0));
    tbl.push_back(mk(1, 4,   0, 1, 1, 1, 10, 0));
    tbl.push_back(mk(0, 0,   0, 1, 1, 0, 10, 0));
    tbl.push_back(mk(1, 5,   0, 0, 1, 0, 10, 0));
    tbl.push_back(mk(1, 5,   0, 0, 1, 0, 10, 0));
    tbl.push_back(mk(1, 5,   0, 0, 1, 0, 10, 0));
    tbl.push_back(mk(1, 5,   0, 0, 1, 1, 20, 0));
    tbl.push_back(mk(0, 0,   1, 0, 0, 1, 20, 0));
    tbl.push_back(mk(0, 0,   0, 1, 1, 0, 20, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].clr, tbl[i].ordy);
      #1;
      chk("tbl_rdy", i, 32'(rdy_d), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk("tbl_ov",  i, 32'(ov_d),  32'(tbl[i].ov));
      chk("tbl_od",  i, 32'(od_d),  32'(tbl[i].od));
      chk("tbl_sat", i, 32'(sat_d), 32'(tbl[i].sat));
    end

    // Saturation on the 16-bit accumulator, and the sticky flag clearing for the next result.
    do_reset();
    step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, 16'h0002, 1'b0, 1'b1);
    step(1'b1, 16'h0000, 1'b0, 1'b1);
    chk("sat_early_ov", 0, 32'(ov_s), 32'h0);
    step(1'b1, 16'h0000, 1'b0, 1'b1);
    chk("sat_ov",  0, 32'(ov_s),  32'h1);
    chk("sat_od",  0, 32'(od_s),  32'hFFFF);
    chk("sat_flag", 0, 32'(sat_s), 32'h1);
    for (int k = 0; k < 4; k++) step(1'b1, 16'h0001, 1'b0, 1'b1);
    chk("sat_next_ov",  0, 32'(ov_s),  32'h1);
    chk("sat_next_od",  0, 32'(od_s),  32'h4);
    chk("sat_next_flag", 0, 32'(sat_s), 32'h0);

    // Single-term instance: every beat completes, drain and refill in the same cycle.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 16'(5 + k), 1'b0, 1'b1);
      chk("one_ov", k, 32'(ov_o), 32'h1);
      chk("one_od", k, 32'(od_o), 32'(5 + k));
    end
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("one_idle_ov", 0, 32'(ov_o), 32'h0);

    // Asynchronous reset with a partial sum in u_def and a held result in u_one.
    do_reset();
    step(1'b1, 16'd3, 1'b0, 1'b0);
    chk("ar_hold_rdy", 0, 32'(rdy_o), 32'h0);
    step(1'b1, 16'd3, 1'b0, 1'b0);
    chk("ar_held_ov", 0, 32'(ov_o), 32'h1);
    chk("ar_held_od", 0, 32'(od_o), 32'h3);
    #1 reset = 1'b0;
    #1;
    chk("ar_ov",  0, 32'(ov_o),  32'h0);
    chk("ar_od",  0, 32'(od_o),  32'h0);
    chk("ar_sat", 0, 32'(sat_o), 32'h0);
    chk("ar_rdy", 0, 32'(rdy_d), 32'h0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1, 16'h0001, 1'b0, 1'b1);
    chk("ar_post_ov", 0, 32'(ov_d), 32'h1);
    chk("ar_post_od", 0, 32'(od_d), 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Accumulates successive 16-bit partial sums from the 3-stage 8-bit adder tree into one wide dot-product result over a programmable number of terms. Sits directly downstream of the adder tree. Upstream control aligns a valid bit with the tree's 3-cycle latency and drives it as in_valid. Presents each finished result on a valid/ready output register with saturation flagging, back-pressuring the tree-side valid pipe when the consumer stalls.

## Interface
- IN_W, 16, width of each incoming partial sum (matches the adder tree output)
- ACC_W, 24, accumulator and result width; must be >= IN_W
- NUM_TERMS, 4, partial sums per result; legal range 1..256
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset: 0 resets, 1 runs
- clear  input  1  synchronous; discards any partial accumulation
- in_valid  input  1  in_data holds a partial sum
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  IN_W  unsigned partial sum
- out_valid  output  1  out_data/out_sat hold a completed result
- out_ready  input  1  consumer accepts the result this cycle
- out_data  output  ACC_W  unsigned accumulated result
- out_sat  output  1  result was clamped

## Operation
- Internal state: acc[ACC_W-1:0], cnt (0..NUM_TERMS-1), sticky sat_pend, output register (out_data, out_sat, out_valid).
- Two states:
  - ACCUM: output register empty, or being drained this cycle.
  - HOLD: out_valid=1 and out_ready=0.
- in_ready = !clear && (!out_valid || out_ready).
- A beat is accepted when in_valid && in_ready.
- sum = acc + in_data, computed at ACC_W+1 bits. If sum > 2^ACC_W-1, clamp to 2^ACC_W-1 and set the overflow term.
- Accepted beat with cnt < NUM_TERMS-1:
  - acc <= clamped sum
  - cnt <= cnt+1
  - sat_pend <= sat_pend | overflow
- Accepted beat with cnt == NUM_TERMS-1:
  - out_data <= clamped sum
  - out_sat <= sat_pend | overflow
  - out_valid <= 1
  - acc, cnt, sat_pend <= 0
- out_valid && out_ready with no completing beat in the same cycle: out_valid <= 0. out_data and out_sat keep their last values.
- Simultaneous drain and completing beat: the new result replaces the old one, out_valid stays 1, and no bubble is inserted.
- clear=1:
  - acc, cnt, sat_pend <= 0.
  - Any in_valid that cycle is not accepted (in_ready=0).
  - Output register and its handshake are unaffected; a pending result remains and can drain.
- NUM_TERMS=1: every accepted beat is a completing beat.
- Reset (reset=0, any time, mid-accumulation or while holding a result):
  - acc, cnt, sat_pend, out_data, out_sat <= 0
  - out_valid <= 0
  - in_ready = 0 while reset=0
  - Partial and pending results are lost.

## Timing
- Reset values: out_valid=0, out_data=0, out_sat=0, in_ready=0 during reset, in_ready=1 in the first cycle after release (with clear=0).
- Latency: out_valid rises on the clock edge that accepts the final term; the result is visible the cycle after that beat is presented.
- Throughput: one beat per cycle while out_ready=1 continuously; one result every NUM_TERMS cycles with no gaps.
- HOLD: in_ready=0 combinationally. out_data and out_sat are stable until the handshake.
- in_ready depends combinationally on out_ready and clear only; there is no path from in_valid to in_ready.
- out_valid, out_data and out_sat are registered outputs.

## Test plan
- **Basic accumulate.** Defaults; out_ready=1; 4 back-to-back beats 100, 200, 300, 400 -> out_valid pulses for 1 cycle, the cycle after the 4th beat; out_data=1000, out_sat=0.
- **Back-pressure.** out_ready=0 after a completed result (value 1000); present 4 more beats of 1 -> in_ready=0 and nothing is accepted; out_data holds 1000. Raise out_ready -> 1000 drains, then the 4 beats are accepted and produce 4.
- **Saturation.** ACC_W=16; beats 0xFFFF, 0x0002, 0, 0 -> out_data=0xFFFF, out_sat=1. The next 4 beats of 1 give out_data=4, out_sat=0 (sticky flag was cleared).
- **Clear mid-stream.** Accept 10, 20; assert clear for 1 cycle while in_valid=1 with 999 -> 999 is not accepted. Then 1, 2, 3, 4 -> out_data=10.
- **Simultaneous drain and complete.** NUM_TERMS=1; out_ready=1; continuous beats 5, 6, 7 -> out_valid high for 3 consecutive cycles with out_data 5, 6, 7.
- **Async reset mid-operation.** After 2 accepted beats and with a held result, pulse reset=0 between clock edges -> out_valid, out_data and out_sat go to 0 immediately without a clock edge. After release, 4 beats of 1 -> out_data=4.
